// File: rtl/logic_sel_unit.sv
// rtl/logic_sel_unit.sv - registered AND32/MUX32/MUX64 select unit; optional zero flag via ZERO_FLAG_EN
module logic_sel_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [1:0]  OP,
  input  logic        S,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [63:0] C,
  input  logic [63:0] D,
  output logic [63:0] Y,
  output logic        VALID,
  output logic        ZERO
);

  localparam logic [1:0] OpAnd32 = 2'b00;
  localparam logic [1:0] OpMux32 = 2'b01;
  localparam logic [1:0] OpMux64 = 2'b10;

  logic [63:0] nextY;

  // Next result from the current operands only; 32-bit ops always clear the upper half.
  always_comb begin
    nextY = 64'h0;
    case (OP)
      OpAnd32: nextY = {32'h0, A & B};
      OpMux32: nextY = {32'h0, (S ? B : A)};
      OpMux64: nextY = S ? D : C;
      default: nextY = 64'h0;
    endcase
  end

  // Result register: capture on EN, otherwise hold; VALID marks the cycle after a capture.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Y     <= 64'h0;
      VALID <= 1'b0;
    end else begin
      VALID <= EN;
      if (EN) begin
        Y <= nextY;
      end
    end
  end

`ifdef ZERO_FLAG_EN
  assign ZERO = (Y == 64'h0);
`else
  assign ZERO = 1'b0;
`endif

endmodule

// File: tb/tb_logic_sel_unit.sv
// tb/tb_logic_sel_unit.sv - directed self-checking bench for logic_sel_unit
module tb_logic_sel_unit;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [1:0]  OP;
  logic        S;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] C;
  logic [63:0] D;
  logic [63:0] Y;
  logic        VALID;
  logic        ZERO;

  int nAsserts = 0;
  int nFails   = 0;

  logic_sel_unit dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .OP    (OP),
    .S     (S),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .Y     (Y),
    .VALID (VALID),
    .ZERO  (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic expZero(input logic [63:0] y);
`ifdef ZERO_FLAG_EN
    return (y == 64'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOut(input string tag, input logic [63:0] expY, input logic expV);
    logic expZ;
    expZ = expZero(expY);
    nAsserts++;
    assert (Y === expY) else begin
      nFails++;
      $error("FAIL %s Y observed=%h expected=%h", tag, Y, expY);
    end
    nAsserts++;
    assert (VALID === expV) else begin
      nFails++;
      $error("FAIL %s VALID observed=%b expected=%b", tag, VALID, expV);
    end
    nAsserts++;
    assert (ZERO === expZ) else begin
      nFails++;
      $error("FAIL %s ZERO observed=%b expected=%b", tag, ZERO, expZ);
    end
  endtask

  task automatic edgeSample();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // reset with arbitrary inputs, checked before the first clock edge
    RST = 1'b1; EN = 1'b1; OP = 2'b10; S = 1'b1;
    A = 32'hDEADBEEF; B = 32'hFFFFFFFF;
    C = 64'h1234_5678_9ABC_DEF0; D = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 RST = 1'b0;
    #1 checkOut("reset_async", 64'h0, 1'b0);
    edgeSample();
    checkOut("reset_ignores_en", 64'h0, 1'b0);

    // release between edges, then first capture: AND32
    RST = 1'b1;
    OP = 2'b00; A = 32'h7FFFFFFF; B = 32'h70000000; EN = 1'b1;
    edgeSample();
    checkOut("and32", 64'h00000000_70000000, 1'b1);

    // MUX32 back-to-back
    OP = 2'b01; A = 32'h80000001; B = 32'h70000000; S = 1'b0;
    edgeSample();
    checkOut("mux32_s0", 64'h00000000_80000001, 1'b1);
    S = 1'b1;
    edgeSample();
    checkOut("mux32_s1", 64'h00000000_70000000, 1'b1);

    // MUX64
    OP = 2'b10; C = 64'h00000000_00000001; D = 64'hFFFFFFFF_00000000; S = 1'b1;
    edgeSample();
    checkOut("mux64_s1", 64'hFFFFFFFF_00000000, 1'b1);
    S = 1'b0;
    edgeSample();
    checkOut("mux64_s0", 64'h00000000_00000001, 1'b1);

    // upper half cleared after a full-width result
    S = 1'b1;
    edgeSample();
    checkOut("mux64_s1_again", 64'hFFFFFFFF_00000000, 1'b1);
    OP = 2'b01; S = 1'b0; A = 32'hA5A5A5A5;
    edgeSample();
    checkOut("mux32_upper_clear", 64'h00000000_A5A5A5A5, 1'b1);

    // reserved op
    OP = 2'b11;
    edgeSample();
    checkOut("reserved", 64'h0, 1'b1);

    // capture nonzero, then hold for 3 edges with changing inputs
    OP = 2'b00; A = 32'h0F0F0F0F; B = 32'hFF00FF00;
    edgeSample();
    checkOut("and32_pattern", 64'h00000000_0F000F00, 1'b1);
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = $urandom; B = $urandom; OP = 2'(i);
      edgeSample();
      checkOut("hold", 64'h00000000_0F000F00, 1'b0);
    end

    // input changes between edges do not disturb outputs
    EN = 1'b1; OP = 2'b10; C = 64'hCAFE_F00D_0000_0001; S = 1'b0;
    #2 checkOut("between_edges", 64'h00000000_0F000F00, 1'b0);
    edgeSample();
    checkOut("mux64_after_hold", 64'hCAFE_F00D_0000_0001, 1'b1);

    // zero result
    OP = 2'b00; A = 32'h0000FFFF; B = 32'hFFFF0000;
    edgeSample();
    checkOut("and32_zero", 64'h0, 1'b1);

    // nonzero capture, then async reset between edges
    OP = 2'b01; S = 1'b1; B = 32'h13579BDF;
    edgeSample();
    checkOut("pre_reset", 64'h00000000_13579BDF, 1'b1);
    #2 RST = 1'b0;
    #1 checkOut("reset_midop", 64'h0, 1'b0);
    edgeSample();
    checkOut("reset_no_capture", 64'h0, 1'b0);

    // first capture after release
    RST = 1'b1; OP = 2'b01; S = 1'b0; A = 32'h00000042;
    edgeSample();
    checkOut("first_after_release", 64'h00000000_00000042, 1'b1);
    EN = 1'b0;
    edgeSample();
    checkOut("valid_drop", 64'h00000000_00000042, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
